// File: rtl/hazard_interlock_unit_pkg.sv
// Shared types and helpers for the hazard interlock unit: the per-stage shadow
// entry, the bubble constant and the source/destination match function.
package hazard_interlock_unit_pkg;

  localparam int REG_AW = 3;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } hz_entry_t;

  localparam hz_entry_t HZ_BUBBLE = '{
    valid:    1'b0,
    regwrite: 1'b0,
    rd:       {REG_AW{1'b0}},
    is_load:  1'b0
  };

  // A stage conflicts when it will write a register the ID instruction reads.
  function automatic logic hz_match(
    input hz_entry_t         entry,
    input logic [REG_AW-1:0] ra,
    input logic [REG_AW-1:0] rb,
    input logic              use_ra,
    input logic              use_rb
  );
    return entry.valid & entry.regwrite &
           ((use_ra & (entry.rd == ra)) | (use_rb & (entry.rd == rb)));
  endfunction

endpackage

// File: rtl/hazard_interlock_unit_checker.sv
// Protocol checker for hazard_interlock_unit, connected alongside the unit.
module hazard_interlock_unit_checker #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  input logic             id_valid,
  input logic             stall_o,
  input logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  a_stall_needs_live_id: assert property (@(posedge clk) disable iff (!rst_n)
    stall_o |-> (id_valid && !flush));

  a_cnt_monotonic: assert property (@(posedge clk) disable iff (!rst_n)
    stall_cnt_o >= $past(stall_cnt_o));

  a_cnt_saturates: assert property (@(posedge clk) disable iff (!rst_n)
    (stall_cnt_o == CNT_MAX) |=> (stall_cnt_o == CNT_MAX));

endmodule

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: async-reset register of hz_entry_t that advances
// with en and loads a bubble instead of d when bubble is set.
module hazard_stage_reg
  import hazard_interlock_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  logic      bubble,
  input  hz_entry_t d,
  output hz_entry_t q
);

  hz_entry_t q_r;

  // Stage state: cleared on reset, holds while the pipeline is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= HZ_BUBBLE;
    end else if (en) begin
      if (bubble) begin
        q_r <= HZ_BUBBLE;
      end else begin
        q_r <= d;
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/hazard_interlock_unit.sv
// Shadow pipeline of in-flight register writes with RAW stall generation.
// Build option HAZARD_FORWARDING_EN: stall only on load-use; otherwise full interlock.
module hazard_interlock_unit
  import hazard_interlock_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_use_ra,
  input  logic              id_use_rb,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  output logic              stall_o,
  output logic              exmem_regwrite_o,
  output logic [REG_AW-1:0] exmem_rd_o,
  output logic              memwb_regwrite_o,
  output logic [REG_AW-1:0] memwb_rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_entry_t        id_entry_s;
  hz_entry_t        idex_r;
  hz_entry_t        exmem_r;
  hz_entry_t        memwb_r;
  logic             raw_stall_s;
  logic             stall_s;
  logic             idex_bubble_s;
  logic [CNT_W-1:0] stall_cnt_r;

  assign id_entry_s = '{
    valid:    id_valid,
    regwrite: id_regwrite,
    rd:       id_rd,
    is_load:  id_is_load
  };

  // A stalled or flushed ID instruction must not enter EX; a bubble goes in instead.
  assign idex_bubble_s = stall_s | flush;

  hazard_stage_reg u_idex (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pipe_en),
    .bubble (idex_bubble_s),
    .d      (id_entry_s),
    .q      (idex_r)
  );

  hazard_stage_reg u_exmem (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pipe_en),
    .bubble (1'b0),
    .d      (idex_r),
    .q      (exmem_r)
  );

  hazard_stage_reg u_memwb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pipe_en),
    .bubble (1'b0),
    .d      (exmem_r),
    .q      (memwb_r)
  );

  // Stall decision; the killed instruction under flush never stalls.
  always_comb begin
    raw_stall_s = 1'b0;
`ifdef HAZARD_FORWARDING_EN
    raw_stall_s = hz_match(idex_r, id_ra, id_rb, id_use_ra, id_use_rb) & idex_r.is_load;
`else
    // No write-through in the register file, so MEMWB still conflicts.
    raw_stall_s = hz_match(idex_r,  id_ra, id_rb, id_use_ra, id_use_rb) |
                  hz_match(exmem_r, id_ra, id_rb, id_use_ra, id_use_rb) |
                  hz_match(memwb_r, id_ra, id_rb, id_use_ra, id_use_rb);
`endif
    stall_s = id_valid & raw_stall_s & ~flush;
  end

  // Saturating count of cycles the pipeline actually spent stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (pipe_en && stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_o          = stall_s;
  assign exmem_regwrite_o = exmem_r.valid & exmem_r.regwrite;
  assign exmem_rd_o       = exmem_r.rd;
  assign memwb_regwrite_o = memwb_r.valid & memwb_r.regwrite;
  assign memwb_rd_o       = memwb_r.rd;
  assign stall_cnt_o      = stall_cnt_r;

endmodule

// File: tb/tb_hazard_interlock_unit.sv
// Directed bench for hazard_interlock_unit; covers either build of HAZARD_FORWARDING_EN.
module tb_hazard_interlock_unit;
  import hazard_interlock_unit_pkg::*;

  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_en;
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_ra;
  logic [REG_AW-1:0] id_rb;
  logic              id_use_ra;
  logic              id_use_rb;
  logic              id_regwrite;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              stall_o;
  logic              exmem_regwrite_o;
  logic [REG_AW-1:0] exmem_rd_o;
  logic              memwb_regwrite_o;
  logic [REG_AW-1:0] memwb_rd_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_interlock_unit #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pipe_en          (pipe_en),
    .flush            (flush),
    .id_valid         (id_valid),
    .id_ra            (id_ra),
    .id_rb            (id_rb),
    .id_use_ra        (id_use_ra),
    .id_use_rb        (id_use_rb),
    .id_regwrite      (id_regwrite),
    .id_rd            (id_rd),
    .id_is_load       (id_is_load),
    .stall_o          (stall_o),
    .exmem_regwrite_o (exmem_regwrite_o),
    .exmem_rd_o       (exmem_rd_o),
    .memwb_regwrite_o (memwb_regwrite_o),
    .memwb_rd_o       (memwb_rd_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  hazard_interlock_unit_checker #(.CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .id_valid    (id_valid),
    .stall_o     (stall_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] ra, input logic ura,
                        input logic [2:0] rb, input logic urb,
                        input logic rw, input logic [2:0] rd, input logic ld);
    id_valid = v; id_ra = ra; id_use_ra = ura; id_rb = rb; id_use_rb = urb;
    id_regwrite = rw; id_rd = rd; id_is_load = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pipe_en = 1'b1; flush = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pipe_en = 1'b1; flush = 1'b0;
    idle();
    #2;
    n_checks++;
    if ({stall_o, exmem_regwrite_o, exmem_rd_o, memwb_regwrite_o, memwb_rd_o, stall_cnt_o} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {stall_o, exmem_regwrite_o, exmem_rd_o, memwb_regwrite_o, memwb_rd_o, stall_cnt_o});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (stall_o !== 1'b0) begin n_fail++; $display("FAIL idle_stall[%0d]: got %b expected 0", i, stall_o); end
    end
    n_checks++;
    if (stall_cnt_o !== 4'd0) begin n_fail++; $display("FAIL idle_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

`ifdef HAZARD_FORWARDING_EN
  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1);   // LD r3
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_pre_stall: got %b expected 0", stall_o); end
    tick();
    set_id(1'b1, 3'd3, 1'b1, 3'd1, 1'b0, 1'b1, 3'd4, 1'b0);   // ADD r4, r3
    #1;
    n_checks++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", stall_o); end
    tick();
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %b expected 0", stall_o); end
    n_checks++;
    if ({exmem_regwrite_o, exmem_rd_o} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL lu_exmem_ld: got %b/%0d expected 1/3", exmem_regwrite_o, exmem_rd_o);
    end
    tick();
    idle();
    n_checks++;
    if (exmem_regwrite_o !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %b expected 0", exmem_regwrite_o); end
    n_checks++;
    if ({memwb_regwrite_o, memwb_rd_o} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL lu_memwb: got %b/%0d expected 1/3", memwb_regwrite_o, memwb_rd_o);
    end
    n_checks++;
    if (stall_cnt_o !== 4'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt_o); end
  endtask

  task automatic test_alu_use();
    do_reset();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0);   // ADD r2
    tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd6, 1'b0);   // SUB r6, r1, r2
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", stall_o); end
    tick();
    idle();
    n_checks++;
    if ({exmem_regwrite_o, exmem_rd_o} !== {1'b1, 3'd2}) begin
      n_fail++; $display("FAIL alu_exmem: got %b/%0d expected 1/2", exmem_regwrite_o, exmem_rd_o);
    end
    n_checks++;
    if (stall_cnt_o !== 4'd0) begin n_fail++; $display("FAIL alu_cnt: got %0d expected 0", stall_cnt_o); end
  endtask
`else
  task automatic test_interlock();
    do_reset();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0);   // ADD r5
    tick();
    set_id(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);   // reader of r5
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (stall_o !== (k < 3)) begin n_fail++; $display("FAIL il_stall[%0d]: got %b expected %b", k, stall_o, (k < 3)); end
      if (k == 1) begin
        n_checks++;
        if ({exmem_regwrite_o, exmem_rd_o} !== {1'b1, 3'd5}) begin
          n_fail++; $display("FAIL il_exmem: got %b/%0d expected 1/5", exmem_regwrite_o, exmem_rd_o);
        end
      end
      if (k == 2) begin
        n_checks++;
        if ({memwb_regwrite_o, memwb_rd_o} !== {1'b1, 3'd5}) begin
          n_fail++; $display("FAIL il_memwb: got %b/%0d expected 1/5", memwb_regwrite_o, memwb_rd_o);
        end
      end
      tick();
    end
    idle();
    n_checks++;
    if (stall_cnt_o !== 4'd3) begin n_fail++; $display("FAIL il_cnt: got %0d expected 3", stall_cnt_o); end
  endtask
`endif

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1);   // LD r3
    tick();
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0);   // ADD r7, r3
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fl_stall: got %b expected 0", stall_o); end
    tick();
    flush = 1'b0;
    idle();
    n_checks++;
    if ({exmem_regwrite_o, exmem_rd_o} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL fl_exmem_ld: got %b/%0d expected 1/3", exmem_regwrite_o, exmem_rd_o);
    end
    tick();
    n_checks++;
    if (exmem_regwrite_o !== 1'b0) begin n_fail++; $display("FAIL fl_bubble: got %b expected 0", exmem_regwrite_o); end
    n_checks++;
    if (stall_cnt_o !== 4'd0) begin n_fail++; $display("FAIL fl_cnt: got %0d expected 0", stall_cnt_o); end

    // Stall while the pipeline is frozen.
    do_reset();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1);
    tick();
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0);
    #1;
    pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({stall_o, exmem_regwrite_o, stall_cnt_o} !== {1'b1, 1'b0, 4'd0}) begin
        n_fail++; $display("FAIL hold[%0d]: got stall=%b exmem=%b cnt=%0d expected 1/0/0", i, stall_o, exmem_regwrite_o, stall_cnt_o);
      end
    end
    pipe_en = 1'b1;
    tick();
    n_checks++;
    if ({exmem_regwrite_o, exmem_rd_o, stall_cnt_o} !== {1'b1, 3'd3, 4'd1}) begin
      n_fail++; $display("FAIL hold_release: got exmem=%b rd=%0d cnt=%0d expected 1/3/1", exmem_regwrite_o, exmem_rd_o, stall_cnt_o);
    end
`ifdef HAZARD_FORWARDING_EN
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL hold_after: got %b expected 0", stall_o); end
`else
    n_checks++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL hold_after: got %b expected 1", stall_o); end
`endif
    idle();
  endtask

  task automatic test_saturation();
    logic exp_stall;
    do_reset();
    // LD r1, r1 repeatedly: every copy depends on the previous one.
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1);
    for (int cyc = 0; cyc < 40; cyc++) begin
`ifdef HAZARD_FORWARDING_EN
      exp_stall = (cyc % 2) == 1;
`else
      exp_stall = (cyc % 4) != 0;
`endif
      #1;
      n_checks++;
      if (stall_o !== exp_stall) begin n_fail++; $display("FAIL sat_stall[%0d]: got %b expected %b", cyc, stall_o, exp_stall); end
      if (cyc == 8) begin
`ifdef HAZARD_FORWARDING_EN
        n_checks++;
        if (stall_cnt_o !== 4'd4) begin n_fail++; $display("FAIL sat_mid_cnt: got %0d expected 4", stall_cnt_o); end
`else
        n_checks++;
        if (stall_cnt_o !== 4'd6) begin n_fail++; $display("FAIL sat_mid_cnt: got %0d expected 6", stall_cnt_o); end
`endif
      end
      tick();
    end
    n_checks++;
    if (stall_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 15", stall_cnt_o); end
    tick();
    #1;
    n_checks++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre_stall: got %b expected 1", stall_o); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stall_o, exmem_regwrite_o, memwb_regwrite_o, exmem_rd_o, memwb_rd_o, stall_cnt_o} !== 13'd0) begin
      n_fail++; $display("FAIL arst_clear: got stall=%b exmem=%b memwb=%b cnt=%0d expected all 0",
                         stall_o, exmem_regwrite_o, memwb_regwrite_o, stall_cnt_o);
    end
    tick();
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
`ifdef HAZARD_FORWARDING_EN
    test_load_use();
    test_alu_use();
`else
    test_interlock();
`endif
    test_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_interlock_unit.md
Name: hazard_interlock_unit

Overview:
- Producer-side companion to the EX-stage forwarding logic. Keeps a shadow pipeline of in-flight register writes across the ID/EX, EX/MEM and MEM/WB stages.
- Drives the EX/MEM and MEM/WB destination and write-enable signals that the forwarding logic consumes.
- Raises a stall to the ID stage when a hazard cannot be bypassed, and inserts a bubble.
- Sits beside the pipeline registers in the core and counts stall cycles for performance monitoring.

Parameters:
REG_AW, 3, register-address width (8 GPRs)
CNT_W, 16, stall-counter width

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
pipe_en  in  1  global pipeline advance (0 = memory wait, all state holds)
flush  in  1  taken branch/jump; kills the instruction in ID
id_valid  in  1  ID holds a real instruction
id_ra  in  REG_AW  source A address
id_rb  in  REG_AW  source B address
id_use_ra  in  1  instruction reads Ra
id_use_rb  in  1  instruction reads Rb
id_regwrite  in  1  instruction writes a register
id_rd  in  REG_AW  destination address
id_is_load  in  1  instruction is LD
stall_o  out  1  hold PC and IF/ID, insert bubble
exmem_regwrite_o  out  1  valid write in EX/MEM
exmem_rd_o  out  REG_AW  EX/MEM destination
memwb_regwrite_o  out  1  valid write in MEM/WB
memwb_rd_o  out  REG_AW  MEM/WB destination
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: all three stage entries are invalid. stall_o=0, *_regwrite_o=0, *_rd_o=0, stall_cnt_o=0.
- Stage entry fields: {valid, regwrite, rd, is_load}.
- Stages: IDEX, EXMEM, MEMWB.
- On a rising edge with pipe_en=1:
  - IDEX <= bubble (all fields 0) if stall_o or flush; otherwise {id_valid, id_regwrite, id_rd, id_is_load}.
  - EXMEM <= IDEX.
  - MEMWB <= EXMEM.
- pipe_en=0: all stages and the counter hold.
- Entry leaving MEMWB is retired: the register file has been written.
- Outputs (registered directly from stage state):
  - exmem_regwrite_o = EXMEM.valid & EXMEM.regwrite; exmem_rd_o = EXMEM.rd.
  - memwb_regwrite_o = MEMWB.valid & MEMWB.regwrite; memwb_rd_o = MEMWB.rd.
- Combinational match, per stage S: S.valid & S.regwrite & ((id_use_ra & S.rd==id_ra) | (id_use_rb & S.rd==id_rb)).
- raw_stall depends on the optional feature (see below).
- stall_o = id_valid & raw_stall & ~flush. Flush wins: the killed instruction never stalls.
- Combinational in, combinational out: stall_o has zero latency from the ID inputs.
- A load-use hazard costs exactly 1 stall cycle with forwarding, and up to 3 without.
- r0 is a normal register; there is no zero-register exemption.
- Stall and pipe_en=0 together: stall_o stays asserted, nothing advances, and the counter does not increment.
- stall_cnt_o increments on each edge with pipe_en & stall_o. It saturates at all-ones and never wraps.
- Reset asserted mid-stall clears all state immediately, without waiting for a clock. stall_o falls as soon as the stage entries are invalid.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: raw_stall = match(IDEX) & IDEX.is_load. Only load-use stalls; all other hazards are left to forwarding.
- Undefined: raw_stall = match(IDEX) | match(EXMEM) | match(MEMWB). This is a full interlock for cores built without the forwarding unit. The register file has no same-cycle write-to-read bypass, so MEMWB is included.
- The exported EXMEM/MEMWB ports exist in both builds.

Decomposition:
- Shared package holds:
  - REG_AW
  - typedef hz_entry_t {valid, regwrite, rd, is_load}
  - constant HZ_BUBBLE (all zero)
  - function hz_match(entry, ra, rb, use_ra, use_rb)
- One sub-module, hazard_stage_reg:
  - an async-reset register of hz_entry_t with enable and a bubble-select input;
  - instantiated three times.

Test Plan:
1. Reset then idle: rst_n low → all outputs 0. Release and drive id_valid=0 for 5 cycles → stall_o=0 throughout, stall_cnt_o=0.
2. Load-use (FORWARDING_EN): LD r3 then ADD using ra=r3 → stall_o=1 for exactly 1 cycle. The bubble reaches exmem_regwrite_o=0 one cycle later, then r3 shows on memwb_rd_o. stall_cnt_o=1.
3. ALU-use (FORWARDING_EN): ADD r2 then SUB using rb=r2 → stall_o=0. Next cycle exmem_regwrite_o=1 and exmem_rd_o=2.
4. Interlock (macro undefined): ADD r5 then a reader of r5 → stall_o=1 for 3 cycles. stall_cnt_o=3.
5. Flush priority: load-use hazard present with flush=1 → stall_o=0 and the IDEX bubble is loaded. Repeat with pipe_en=0 during the stall → state and counter hold.
6. Saturation and async reset: force CNT_W=4 and stall for 20 cycles → stall_cnt_o=15. Pulse rst_n low between edges → outputs clear before the next clk edge.
